// File: rtl/multi_pulse_generator.sv
// Multi-channel edge-to-pulse converter: each channel turns a selected edge on
// its level input into a registered pulse of PULSE_LEN clk cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no pulse in progress; waiting for an enabled qualifying edge
// ACTIVE | pulse high; cnt holds the remaining cycles after this one
module multi_pulse_generator #(
   parameter int CHANNELS    = 4,
   parameter int PULSE_LEN   = 1,
   parameter int SYNC_STAGES = 0,
   parameter int RETRIGGER   = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] a,
   input  logic [CHANNELS-1:0] en,
   input  logic [1:0]          mode,
   input  logic                clear,
   output logic [CHANNELS-1:0] pulse,
   output logic                pulse_any,
   output logic [CHANNELS-1:0] overrun
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   localparam logic [7:0] RELOAD = 8'(PULSE_LEN - 1);

   state_t              state     [CHANNELS];
   state_t              state_nxt [CHANNELS];
   logic [7:0]          cnt       [CHANNELS];
   logic [7:0]          cnt_nxt   [CHANNELS];
   logic [CHANNELS-1:0] a_s;
   logic [CHANNELS-1:0] a_prev;
   logic [CHANNELS-1:0] edge_det;
   logic [CHANNELS-1:0] pulse_nxt;
   logic [CHANNELS-1:0] overrun_nxt;

   generate
      if (SYNC_STAGES == 2) begin : g_sync
         logic [CHANNELS-1:0] sync1;
         logic [CHANNELS-1:0] sync2;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync1 <= '0;
               sync2 <= '0;
            end else begin
               sync1 <= a;
               sync2 <= sync1;
            end
         end
         assign a_s = sync2;
      end else begin : g_nosync
         assign a_s = a;
      end
   endgenerate

   always_comb begin
      edge_det = '0;
      case (mode)
         2'b00:   edge_det = a_s & ~a_prev;
         2'b01:   edge_det = ~a_s & a_prev;
         2'b10:   edge_det = a_s ^ a_prev;
         default: edge_det = '0;
      endcase
   end

   // Overrun set takes priority over clear because the set is applied last.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_nxt[i]   = state[i];
         cnt_nxt[i]     = cnt[i];
         pulse_nxt[i]   = 1'b0;
         overrun_nxt[i] = overrun[i] & ~clear;
         case (state[i])
            IDLE: begin
               if (en[i] && edge_det[i]) begin
                  state_nxt[i] = ACTIVE;
                  cnt_nxt[i]   = RELOAD;
                  pulse_nxt[i] = 1'b1;
               end
            end
            ACTIVE: begin
               if (!en[i]) begin
                  state_nxt[i] = IDLE;
               end else if (edge_det[i] && (RETRIGGER != 0)) begin
                  cnt_nxt[i]   = RELOAD;
                  pulse_nxt[i] = 1'b1;
               end else begin
                  if (edge_det[i])
                     overrun_nxt[i] = 1'b1;
                  if (cnt[i] == 8'd0) begin
                     state_nxt[i] = IDLE;
                  end else begin
                     cnt_nxt[i]   = cnt[i] - 8'd1;
                     pulse_nxt[i] = 1'b1;
                  end
               end
            end
            default: state_nxt[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= 8'd0;
         end
         a_prev    <= '0;
         pulse     <= '0;
         pulse_any <= 1'b0;
         overrun   <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
         a_prev    <= a_s;
         pulse     <= pulse_nxt;
         pulse_any <= |pulse_nxt;
         overrun   <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator: four instances with different
// parameter sets share one stimulus stream; each test checks its own instance.
module tb_multi_pulse_generator;

   logic       clk;
   logic       reset;
   logic [3:0] a;
   logic [3:0] en;
   logic [1:0] mode;
   logic       clear;

   logic [3:0] pulse0, pulse1, pulse2, pulse3;
   logic       any0, any1, any2, any3;
   logic [3:0] ovr0, ovr1, ovr2, ovr3;

   int n_chk  = 0;
   int n_pass = 0;
   int cnt_u0, cnt_u3, first_u0, first_u3;

   // u0 defaults, u1 len 4 no retrigger, u2 len 4 retrigger, u3 len 1 synchronised
   multi_pulse_generator #(.CHANNELS(4), .PULSE_LEN(1), .SYNC_STAGES(0), .RETRIGGER(0)) u0 (
      .clk(clk), .reset(reset), .a(a), .en(en), .mode(mode), .clear(clear),
      .pulse(pulse0), .pulse_any(any0), .overrun(ovr0));
   multi_pulse_generator #(.CHANNELS(4), .PULSE_LEN(4), .SYNC_STAGES(0), .RETRIGGER(0)) u1 (
      .clk(clk), .reset(reset), .a(a), .en(en), .mode(mode), .clear(clear),
      .pulse(pulse1), .pulse_any(any1), .overrun(ovr1));
   multi_pulse_generator #(.CHANNELS(4), .PULSE_LEN(4), .SYNC_STAGES(0), .RETRIGGER(1)) u2 (
      .clk(clk), .reset(reset), .a(a), .en(en), .mode(mode), .clear(clear),
      .pulse(pulse2), .pulse_any(any2), .overrun(ovr2));
   multi_pulse_generator #(.CHANNELS(4), .PULSE_LEN(1), .SYNC_STAGES(2), .RETRIGGER(0)) u3 (
      .clk(clk), .reset(reset), .a(a), .en(en), .mode(mode), .clear(clear),
      .pulse(pulse3), .pulse_any(any3), .overrun(ovr3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; a = 4'h0; en = 4'hF; mode = 2'b00; clear = 1'b0;
      tick(); tick();
      check("reset_pulse0", 32'(pulse0), 32'h0);
      check("reset_any0", 32'(any0), 32'h0);
      check("reset_pulse1", 32'(pulse1), 32'h0);
      check("reset_ovr1", 32'(ovr1), 32'h0);
      reset = 1'b0;
      tick();

      // single-cycle rising pulse, and the same edge two cycles later through the synchroniser
      a = 4'b0001;
      tick();
      check("t1_u0_pulse_k", 32'(pulse0), 32'h1);
      check("t1_u0_any_k", 32'(any0), 32'h1);
      check("t1_u3_pulse_k", 32'(pulse3), 32'h0);
      tick();
      check("t1_u0_pulse_k1", 32'(pulse0), 32'h0);
      check("t1_u0_any_k1", 32'(any0), 32'h0);
      check("t1_u3_pulse_k1", 32'(pulse3), 32'h0);
      tick();
      check("t1_u3_pulse_k2", 32'(pulse3), 32'h1);
      check("t1_u3_any_k2", 32'(any3), 32'h1);
      check("t1_u0_held", 32'(pulse0), 32'h0);
      tick();
      check("t1_u3_pulse_k3", 32'(pulse3), 32'h0);
      a = 4'b0000;
      repeat (4) tick();

      // falling-edge mode: rise ignored, fall gives 4 cycles
      mode = 2'b01;
      a = 4'b0010;
      tick();
      check("t2_rise_ignored_a", 32'(pulse1), 32'h0);
      tick();
      check("t2_rise_ignored_b", 32'(pulse1), 32'h0);
      a = 4'b0000;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("t2_fall_c%0d", i), 32'(pulse1), (i <= 4) ? 32'h2 : 32'h0);
      end
      repeat (2) tick();

      // both-edge mode, second edge ignored and flagged
      mode = 2'b10;
      a = 4'b0100;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("t3_pulse_c%0d", i), 32'(pulse1), (i <= 4) ? 32'h4 : 32'h0);
         if (i == 2) begin
            check("t3_ovr_before", 32'(ovr1), 32'h0);
            a = 4'b0000;
         end
         if (i == 3) check("t3_ovr_set", 32'(ovr1), 32'h4);
      end
      check("t3_ovr_sticky", 32'(ovr1), 32'h4);
      check("t3_u2_no_ovr", 32'(ovr2), 32'h0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t3_ovr_cleared", 32'(ovr1), 32'h0);
      a = 4'b0100;
      tick();
      a = 4'b0000;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t3_set_beats_clear", 32'(ovr1), 32'h4);
      repeat (5) tick();

      // retrigger: edges 3 cycles apart keep the pulse high for 10 cycles
      a = 4'b1000;
      for (int i = 1; i <= 11; i++) begin
         tick();
         check($sformatf("t4_retrig_c%0d", i), 32'(pulse2), (i <= 10) ? 32'h8 : 32'h0);
         if (i == 3 || i == 6) a[3] = ~a[3];
      end
      check("t4_u2_no_ovr", 32'(ovr2), 32'h0);

      // enable dropped mid-pulse truncates it
      mode = 2'b00;
      tick();
      a = 4'b1100;
      tick();
      check("t5_start", 32'(pulse1), 32'h4);
      tick();
      check("t5_mid", 32'(pulse1), 32'h4);
      en = 4'b1011;
      tick();
      check("t5_truncated", 32'(pulse1), 32'h0);
      en = 4'hF;
      tick();
      check("t5_no_restart", 32'(pulse1), 32'h0);

      // reset mid-pulse drops outputs asynchronously; nothing after release
      a = 4'b1110;
      tick();
      check("t6_start", 32'(pulse1), 32'h2);
      a = 4'b0000;
      #2 reset = 1'b1;
      #1;
      check("t6_async_pulse", 32'(pulse1), 32'h0);
      check("t6_async_any", 32'(any1), 32'h0);
      tick();
      reset = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("t6_quiet_c%0d", i), 32'(pulse1 | pulse0), 32'h0);
      end

      // input held high across reset release: exactly one pulse each
      reset = 1'b1;
      a = 4'b0001;
      tick(); tick();
      reset = 1'b0;
      cnt_u0 = 0; cnt_u3 = 0; first_u0 = 0; first_u3 = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (pulse0[0]) begin cnt_u0++; if (first_u0 == 0) first_u0 = i; end
         if (pulse3[0]) begin cnt_u3++; if (first_u3 == 0) first_u3 = i; end
      end
      check("t7_u0_count", 32'(cnt_u0), 32'd1);
      check("t7_u3_count", 32'(cnt_u3), 32'd1);
      check("t7_u0_first", 32'(first_u0), 32'd1);
      check("t7_u3_first", 32'(first_u3), 32'd3);

      // simultaneous edges on every channel
      a = 4'b0000;
      tick(); tick();
      a = 4'b1111;
      tick();
      check("t8_all_pulse", 32'(pulse0), 32'hF);
      check("t8_all_any", 32'(any0), 32'h1);
      tick();
      check("t8_all_done", 32'(pulse0), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
